// File: rtl/phase_sequencer.sv
// Run/stop/step controller generating five non-overlapping phase clocks for the SIMPLE pipeline.
// Define PHASE_SEQ_BKPT_EN to enable the PC breakpoint comparator.
module phase_sequencer #(
    parameter int PHASE_HIGH = 1,
    parameter int PHASE_LOW  = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             exec,
    input  logic             step,
    input  logic             halt_in,
    input  logic [15:0]      pc,
    input  logic [15:0]      bkpt_addr,
    output logic             clockp1,
    output logic             clockp2,
    output logic             clockp3,
    output logic             clockp4,
    output logic             clockp5,
    output logic             running,
    output logic             halted,
    output logic             bkpt_hit,
    output logic [CNT_W-1:0] instr_count
);

    localparam int PMAX = (PHASE_HIGH > PHASE_LOW) ? PHASE_HIGH : PHASE_LOW;
    localparam int TW   = $clog2(PMAX) + 1;
    localparam logic [TW-1:0] HI_LAST = TW'(PHASE_HIGH - 1);
    localparam logic [TW-1:0] LO_LAST = TW'(PHASE_LOW - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP, S_HALTED} state_t;

    state_t            state, state_n;
    logic [2:0]        phase, phase_n;
    logic              high, high_n;
    logic [TW-1:0]     timer, timer_n;
    logic              stop_req, stop_n;
    logic              skip, skip_n;
    logic [CNT_W-1:0]  count_n;
    logic [4:0]        pclk, pclk_n;
    logic              running_n, halted_n, hit_n;
    logic              start_p1, bkpt_stop;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            phase       <= 3'd1;
            high        <= 1'b0;
            timer       <= '0;
            stop_req    <= 1'b0;
            skip        <= 1'b0;
            pclk        <= '0;
            running     <= 1'b0;
            halted      <= 1'b0;
            bkpt_hit    <= 1'b0;
            instr_count <= '0;
        end else begin
            state       <= state_n;
            phase       <= phase_n;
            high        <= high_n;
            timer       <= timer_n;
            stop_req    <= stop_n;
            skip        <= skip_n;
            pclk        <= pclk_n;
            running     <= running_n;
            halted      <= halted_n;
            bkpt_hit    <= hit_n;
            instr_count <= count_n;
        end
    end

    always_comb begin
        state_n  = state;
        phase_n  = phase;
        high_n   = high;
        timer_n  = timer;
        stop_n   = stop_req;
        skip_n   = skip;
        count_n  = instr_count;
        hit_n    = 1'b0;
        start_p1 = 1'b0;

        case (state)
            S_IDLE: begin
                if (exec) begin
                    state_n  = S_RUN;
                    start_p1 = 1'b1;
                end else if (step) begin
                    state_n  = S_STEP;
                    start_p1 = 1'b1;
                end
            end
            S_RUN, S_STEP: begin
                if (state == S_RUN && exec)
                    stop_n = 1'b1;
                if (high) begin
                    if (timer == HI_LAST) begin
                        high_n  = 1'b0;
                        timer_n = '0;
                    end else begin
                        timer_n = timer + 1'b1;
                    end
                end else if (timer != LO_LAST) begin
                    timer_n = timer + 1'b1;
                end else if (phase != 3'd5) begin
                    phase_n = phase + 3'd1;
                    high_n  = 1'b1;
                    timer_n = '0;
                end else begin
                    // Last low cycle of p5: retire, then pick the next state in the same edge.
                    count_n = instr_count + 1'b1;
                    phase_n = 3'd1;
                    timer_n = '0;
                    if (halt_in) begin
                        state_n = S_HALTED;
                        stop_n  = 1'b0;
                    end else if (state == S_STEP || stop_req || exec) begin
                        state_n = S_IDLE;
                        stop_n  = 1'b0;
                    end else begin
                        start_p1 = 1'b1;
                    end
                end
            end
            default: ;
        endcase

`ifdef PHASE_SEQ_BKPT_EN
        bkpt_stop = start_p1 && (state_n == S_RUN) && (pc == bkpt_addr) && !skip;
`else
        bkpt_stop = 1'b0;
`endif

        if (bkpt_stop) begin
            state_n = S_IDLE;
            stop_n  = 1'b0;
            phase_n = 3'd1;
            high_n  = 1'b0;
            timer_n = '0;
            skip_n  = 1'b1;
            hit_n   = 1'b1;
        end else if (start_p1) begin
            phase_n = 3'd1;
            high_n  = 1'b1;
            timer_n = '0;
            skip_n  = 1'b0;
        end

        running_n = (state_n == S_RUN) || (state_n == S_STEP);
        halted_n  = (state_n == S_HALTED);
        pclk_n    = (running_n && high_n) ? (5'd1 << (phase_n - 3'd1)) : 5'd0;
    end

`ifndef PHASE_SEQ_BKPT_EN
    logic unused_bkpt;
    assign unused_bkpt = ^{pc, bkpt_addr};
`endif

    assign clockp1 = pclk[0];
    assign clockp2 = pclk[1];
    assign clockp3 = pclk[2];
    assign clockp4 = pclk[3];
    assign clockp5 = pclk[4];

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: dut a (1/1 phases, 4-bit count), dut b (2/3 phases).
module tb_phase_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        exec_a, step_a, halt_a, exec_b, step_b;
    logic [15:0] pc_a, bk_a;
    logic [15:0] pc_b, bk_b;
    logic [4:0]  ca, cb;
    logic        run_a, hlt_a, hit_a, run_b, hlt_b, hit_b;
    logic [3:0]  cnt_a;
    logic [15:0] cnt_b;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    phase_sequencer #(.PHASE_HIGH(1), .PHASE_LOW(1), .CNT_W(4)) ua (
        .clock(clk), .reset(reset), .exec(exec_a), .step(step_a), .halt_in(halt_a),
        .pc(pc_a), .bkpt_addr(bk_a),
        .clockp1(ca[0]), .clockp2(ca[1]), .clockp3(ca[2]), .clockp4(ca[3]), .clockp5(ca[4]),
        .running(run_a), .halted(hlt_a), .bkpt_hit(hit_a), .instr_count(cnt_a)
    );

    phase_sequencer #(.PHASE_HIGH(2), .PHASE_LOW(3), .CNT_W(16)) ub (
        .clock(clk), .reset(reset), .exec(exec_b), .step(step_b), .halt_in(1'b0),
        .pc(pc_b), .bkpt_addr(bk_b),
        .clockp1(cb[0]), .clockp2(cb[1]), .clockp3(cb[2]), .clockp4(cb[3]), .clockp5(cb[4]),
        .running(run_b), .halted(hlt_b), .bkpt_hit(hit_b), .instr_count(cnt_b)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_exec_a();
        exec_a = 1'b1;
        tick(1);
        exec_a = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            tests++;
            assert ($onehot0(ca) && $onehot0(cb)) else begin
                fails++;
                $error("FAIL onehot observed=%b/%b expected=onehot0", ca, cb);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] acc;
        logic [4:0] exp;
        reset = 1'b1;
        exec_a = 0; step_a = 0; halt_a = 0; exec_b = 0; step_b = 0;
        pc_a = 16'h0000; bk_a = 16'hFFFF; pc_b = 16'h0000; bk_b = 16'hFFFF;
        tick(2);
        chk("rst_clk", {27'd0, ca}, 0);
        chk("rst_cnt", {28'd0, cnt_a}, 0);
        chk("rst_run", {31'd0, run_a}, 0);
        reset = 1'b0;

        // Run: phase timing with 1/1 phases
        pulse_exec_a();
        chk("run_p1", {27'd0, ca}, 5'b00001);
        chk("run_running", {31'd0, run_a}, 1);
        tick(1);  chk("run_p1_low", {27'd0, ca}, 0);
        tick(1);  chk("run_p2", {27'd0, ca}, 5'b00010);
        tick(2);  chk("run_p3", {27'd0, ca}, 5'b00100);
        tick(2);  chk("run_p4", {27'd0, ca}, 5'b01000);
        tick(2);  chk("run_p5", {27'd0, ca}, 5'b10000);
        chk("run_cnt0", {28'd0, cnt_a}, 0);
        tick(1);  chk("run_p5_low", {27'd0, ca}, 0);
        chk("run_cnt_still0", {28'd0, cnt_a}, 0);
        tick(1);  chk("run_p1_again", {27'd0, ca}, 5'b00001);
        chk("run_cnt1", {28'd0, cnt_a}, 1);

        // Reset mid-p3 of instruction 2
        tick(4);  chk("pre_rst_p3", {27'd0, ca}, 5'b00100);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_clk", {27'd0, ca}, 0);
        chk("rst_mid_run", {31'd0, run_a}, 0);
        chk("rst_mid_cnt", {28'd0, cnt_a}, 0);
        #2 reset = 1'b0;
        tick(1);
        chk("post_rst_idle", {27'd0, ca}, 0);
        chk("post_rst_run", {31'd0, run_a}, 0);

        // Stop request during p2 of instruction 3
        pulse_exec_a();
        tick(22); chk("stop_i3_p2", {27'd0, ca}, 5'b00010);
        pulse_exec_a();
        tick(6);  chk("stop_cnt2", {28'd0, cnt_a}, 2);
        chk("stop_still_run", {31'd0, run_a}, 1);
        tick(1);  chk("stop_cnt3", {28'd0, cnt_a}, 3);
        chk("stop_idle", {31'd0, run_a}, 0);
        acc = '0;
        for (int i = 0; i < 10; i++) begin
            acc |= ca;
            tick(1);
        end
        chk("stop_no_more_clk", {27'd0, acc}, 0);
        chk("stop_cnt_hold", {28'd0, cnt_a}, 3);

        // Count wrap with 4-bit counter
        do_reset();
        pulse_exec_a();
        tick(149); chk("wrap_cnt14", {28'd0, cnt_a}, 14);
        tick(1);   chk("wrap_cnt15", {28'd0, cnt_a}, 15);
        tick(10);  chk("wrap_cnt0", {28'd0, cnt_a}, 0);
        pulse_exec_a();
        tick(9);   chk("wrap_stop_idle", {31'd0, run_a}, 0);
        chk("wrap_cnt1", {28'd0, cnt_a}, 1);

        // Halt raised during p4 of instruction 1
        do_reset();
        pulse_exec_a();
        tick(6);  chk("halt_p4", {27'd0, ca}, 5'b01000);
        halt_a = 1'b1;
        tick(2);  chk("halt_p5_done", {27'd0, ca}, 5'b10000);
        chk("halt_not_yet", {31'd0, hlt_a}, 0);
        tick(1);  chk("halt_not_yet2", {31'd0, hlt_a}, 0);
        tick(1);  chk("halted", {31'd0, hlt_a}, 1);
        chk("halt_cnt1", {28'd0, cnt_a}, 1);
        chk("halt_run0", {31'd0, run_a}, 0);
        chk("halt_clk0", {27'd0, ca}, 0);
        pulse_exec_a();
        step_a = 1'b1; tick(1); step_a = 1'b0;
        tick(3);
        chk("halt_ign_clk", {27'd0, ca}, 0);
        chk("halt_ign_run", {31'd0, run_a}, 0);
        chk("halt_ign_cnt", {28'd0, cnt_a}, 1);
        halt_a = 1'b0;
        tick(2);  chk("halt_sticky", {31'd0, hlt_a}, 1);

        // Breakpoint: pc reaches bkpt_addr during instruction 1
        do_reset();
        pc_a = 16'h0003; bk_a = 16'h0004;
        pulse_exec_a();
        tick(4);  pc_a = 16'h0004;
        tick(6);
`ifdef PHASE_SEQ_BKPT_EN
        chk("bkpt_no_p1", {27'd0, ca}, 0);
        chk("bkpt_hit", {31'd0, hit_a}, 1);
        chk("bkpt_idle", {31'd0, run_a}, 0);
        chk("bkpt_cnt", {28'd0, cnt_a}, 1);
        tick(1);  chk("bkpt_hit_pulse", {31'd0, hit_a}, 0);
        pulse_exec_a();
        chk("bkpt_resume_p1", {27'd0, ca}, 5'b00001);
        chk("bkpt_resume_nohit", {31'd0, hit_a}, 0);
`else
        chk("nobkpt_p1", {27'd0, ca}, 5'b00001);
        chk("nobkpt_hit0", {31'd0, hit_a}, 0);
        chk("nobkpt_cnt", {28'd0, cnt_a}, 1);
`endif
        pulse_exec_a();
        tick(12); chk("bkpt_stop_idle", {31'd0, run_a}, 0);
        chk("bkpt_cnt2", {28'd0, cnt_a}, 2);

        // Step with 2/3 phases on dut b
        step_b = 1'b1; tick(1); step_b = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            exp = (((c - 1) % 5) < 2) ? (5'd1 << ((c - 1) / 5)) : 5'd0;
            chk($sformatf("step_c%0d", c), {27'd0, cb}, {27'd0, exp});
            tick(1);
        end
        chk("step_cnt1", cnt_b, 1);
        chk("step_idle", {31'd0, run_b}, 0);
        chk("step_clk0", {27'd0, cb}, 0);

        // exec and step together: exec wins, runs back to back
        exec_b = 1'b1; step_b = 1'b1; tick(1); exec_b = 1'b0; step_b = 1'b0;
        chk("both_p1", {27'd0, cb}, 5'b00001);
        chk("both_running", {31'd0, run_b}, 1);
        tick(25); chk("both_next_p1", {27'd0, cb}, 5'b00001);
        chk("both_cnt2", cnt_b, 2);
        exec_b = 1'b1; tick(1); exec_b = 1'b0;
        tick(30); chk("both_stop_idle", {31'd0, run_b}, 0);
        chk("both_cnt3", cnt_b, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
